// File: rtl/merge2_pkg.sv
// Shared types and constants for the two-input round-robin merge stage.
// The MERGE2_RR_CNT_EN build option adds per-channel delivery counters to merge2_rr.
package merge2_pkg;

   typedef enum logic {
      SRC0 = 1'b0,
      SRC1 = 1'b1
   } src_t;

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

   // Returns the channel opposite to s (round-robin tie break).
   function automatic src_t other_src(input src_t s);
      return (s == SRC0) ? SRC1 : SRC0;
   endfunction

endpackage

// File: rtl/merge2_slot.sv
// One-entry holding slot: data register plus full flag, with a registered ready output.
// Load and drain are never asserted together, because the slot only loads while empty.
module merge2_slot #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] data_o
);

   logic             full_q, full_d;
   logic             ready_q, ready_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (load_i) begin
         full_d = 1'b1;
         data_d = data_i;
      end
      if (drain_i) begin
         full_d = 1'b0;
      end
      ready_d = ~full_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         ready_q <= 1'b1;
         data_q  <= '0;
      end else begin
         full_q  <= full_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign full_o  = full_q;
   assign ready_o = ready_q;
   assign data_o  = data_q;

endmodule

// File: rtl/merge2_rr.sv
// Merges two demux branch streams into one tagged valid/ready stream via round-robin arbitration.
// Defining MERGE2_RR_CNT_EN adds saturating per-channel delivery counters cnt0/cnt1.
module merge2_rr
   import merge2_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   input  logic             out_ready
`ifdef MERGE2_RR_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
`endif
);

   logic             full0, full1;
   logic [WIDTH-1:0] slot_data0, slot_data1;
   logic             load0, load1;
   logic             drain0, drain1;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   src_t             out_src_q, out_src_d;
   src_t             last_grant_q, last_grant_d;

   logic             out_free;
   logic             pick_vld;
   src_t             grant;

   assign load0 = in0_valid & in0_ready;
   assign load1 = in1_valid & in1_ready;

   merge2_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load0),
      .drain_i (drain0),
      .data_i  (in0_data),
      .full_o  (full0),
      .ready_o (in0_ready),
      .data_o  (slot_data0)
   );

   merge2_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load1),
      .drain_i (drain1),
      .data_i  (in1_data),
      .full_o  (full1),
      .ready_o (in1_ready),
      .data_o  (slot_data1)
   );

   // Output register can take a new word when empty or emptying this cycle.
   assign out_free = ~out_valid_q | out_ready;

   // Round-robin pick: a lone full slot wins, a tie goes opposite the last grant.
   always_comb begin
      pick_vld = 1'b0;
      grant    = SRC0;
      if (out_free) begin
         if (full0 && full1) begin
            pick_vld = 1'b1;
            grant    = other_src(last_grant_q);
         end else if (full0) begin
            pick_vld = 1'b1;
            grant    = SRC0;
         end else if (full1) begin
            pick_vld = 1'b1;
            grant    = SRC1;
         end
      end
   end

   assign drain0 = pick_vld & (grant == SRC0);
   assign drain1 = pick_vld & (grant == SRC1);

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      if (out_free) begin
         out_valid_d = pick_vld;
         if (pick_vld) begin
            out_data_d   = (grant == SRC0) ? slot_data0 : slot_data1;
            out_src_d    = grant;
            last_grant_d = grant;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= SRC0;
         last_grant_q <= SRC1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

`ifdef MERGE2_RR_CNT_EN
   logic             out_hs;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   assign out_hs = out_valid_q & out_ready;

   // Saturating delivery counters, stepped on each output handshake.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (out_hs && (out_src_q == SRC0) && (cnt0_q != CNT_MAX)) begin
         cnt0_d = cnt0_q + CNT_W'(1);
      end
      if (out_hs && (out_src_q == SRC1) && (cnt1_q != CNT_MAX)) begin
         cnt1_d = cnt1_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign cnt0 = cnt0_q;
   assign cnt1 = cnt1_q;
`endif

endmodule

// File: doc/merge2_rr.md
# merge2_rr

Two-input merge stage that recombines the two branch streams produced by the team's 1-to-2 demultiplexer into a single output stream. Each input has a one-entry holding slot. A round-robin arbiter moves slot contents into a registered output stage that uses a valid/ready handshake. The output carries a source tag, so downstream logic knows which demux branch each word came from.

## Interface
Parameters:
- WIDTH, 8, data width of every input and output word

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk
- in0_valid  in  1  channel 0 word present
- in0_data  in  WIDTH  channel 0 word
- in0_ready  out  1  channel 0 slot empty; transfer occurs when in0_valid && in0_ready at a clk edge
- in1_valid  in  1  channel 1 word present
- in1_data  in  WIDTH  channel 1 word
- in1_ready  out  1  channel 1 slot empty
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  output word
- out_src  out  1  source channel of out_data: 0 or 1
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready
- cnt0, cnt1  out  16 each  present only with MERGE2_RR_CNT_EN; count of words delivered from each channel

## Operation
- Slot N is the holding register for channel N, with a full flag.
  - inN_ready = ~fullN. This is purely registered, with no combinational path from out_ready.
  - On accept, slot N captures inN_data and sets fullN.
- The output register is "free" when out_valid is 0, or when out_valid && out_ready in the current cycle.
- When the output register is free and at least one slot is full, the arbiter picks one slot:
  - only one slot full → pick that slot;
  - both slots full → pick the slot opposite last_grant.
- On a pick:
  - the chosen slot's data loads into out_data, and its index loads into out_src;
  - out_valid is set and the chosen full flag is cleared;
  - last_grant is updated to the chosen index.
- When the output is free and no slot is full, out_valid clears at the edge.
- While out_valid && !out_ready, out_data, out_src and out_valid hold stable and the slots hold their contents.
- Input words on in0_data and in1_data are never altered or reordered within a channel.

## Timing
- Reset values:
  - in0_ready = 1, in1_ready = 1;
  - out_valid = 0, out_data = 0, out_src = 0;
  - full0 = full1 = 0;
  - last_grant = 1, so channel 0 wins the first tie;
  - cnt0 = cnt1 = 0.
- Latency: an input accepted at edge t appears with out_valid at edge t+1. The slot loads at t; if the output is free at t+1, the output loads then.
- A slot cannot load and drain in the same edge, because ready is low while the slot is full.
- Throughput:
  - one channel alone delivers 1 word per 2 cycles;
  - both channels active deliver 1 word per cycle, alternating 0,1,0,1.
- Backpressure: while out_ready is held 0, at most 3 words are stored (2 slots + output). Both inN_ready then drop and stay low.
- If reset is asserted mid-transfer, all words in flight are discarded and the block returns to reset values with no partial output.

## Configuration
- MERGE2_RR_CNT_EN
  - Defined: cnt0 and cnt1 exist. cntN increments by 1 on each output handshake where out_src = N and saturates at 0xFFFF without wrapping.
  - Undefined: the counter ports and logic are absent, and all other behaviour is identical.

## Structure
- Package merge2_pkg holds:
  - src_t, a 1-bit enum with values SRC0 = 0 and SRC1 = 1, used for out_src and last_grant;
  - localparam CNT_W = 16;
  - CNT_MAX = 16'hFFFF.
- Sub-module merge2_slot: one-entry data register plus full flag, with load and drain controls and a ready output. It is instantiated twice.
- The arbiter and output register stay in the top-level module.

## Test plan
- Reset, then drive in0 with 8'hA5 only while out_ready = 1. Required:
  - out_valid goes high 2 edges after reset release + accept, with out_data = 8'hA5 and out_src = 0;
  - in0_ready is low for exactly one cycle.
- Make both inputs valid from reset (in0 = 8'h10, 8'h11; in1 = 8'h20, 8'h21) with out_ready = 1. Required output order: 10/0, 20/1, 11/0, 21/1, on consecutive cycles once the pipeline is filled.
- Hold out_ready = 0 and offer 4 words on each channel. Required:
  - exactly 3 are accepted, then in0_ready = in1_ready = 0;
  - out_data holds stable;
  - after out_ready is released, all 3 drain in round-robin order with no loss.
- Assert rst_n low with both slots full and out_valid = 1. Required:
  - out_valid = 0 and both ready signals = 1 immediately, without waiting for clk;
  - no stale word appears after release.
- With MERGE2_RR_CNT_EN defined, deliver 5 words from channel 0 and 3 from channel 1. Required: cnt0 = 5, cnt1 = 3.
- With MERGE2_RR_CNT_EN defined, preload cnt1 near 0xFFFF and deliver 2 more channel-1 words. Required: cnt1 stays at 0xFFFF.
